// File: rtl/dualportram_pkg.sv
// Shared types and helpers for the dualportram_clr RAM and its clear sequencer.
package dualportram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    localparam int BE_LANE_W = 8;

    // Bit mask of the implemented bits in the top byte lane when WIDTH is not a multiple of 8.
    function automatic logic [BE_LANE_W-1:0] topLaneMask(input int width);
        int rem;
        rem = width % BE_LANE_W;
        if (rem == 0) begin
            return '1;
        end
        return BE_LANE_W'((1 << rem) - 1);
    endfunction

endpackage

// File: rtl/dualportram_clr_seq.sv
// Clear engine for dualportram_clr: sweeps every word once after reset and on each clear request.
module dualportram_clr_seq
    import dualportram_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    output logic             busy,
    output logic             clr_we,
    output logic [DEPTH-1:0] clr_addr
);

    localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(WORDS - 1);

    state_e           state_q, state_d;
    logic [DEPTH-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // A clear request seen while already sweeping is ignored; the sweep never restarts.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/dualportram_clr.sv
// Dual-port RAM with byte enables, registered read port and a hardware clear engine.
// Optional write-through forwarding on read/write collisions: define DUALPORTRAM_CLR_BYPASS_EN.
module dualportram_clr
    import dualportram_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH      = 10,
    parameter int              WORDS      = 1024,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int              BE_W       = (WIDTH + 7) / 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      length,
    output logic             busy,
    input  logic             clear_req,
    input  logic [31:0]      waddress,
    input  logic [WIDTH-1:0] din,
    input  logic [BE_W-1:0]  wbe,
    input  logic             we,
    input  logic [31:0]      raddress,
    input  logic             oe,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             oor
);

    localparam logic [DEPTH:0] WORDS_L = (DEPTH + 1)'(WORDS);

    logic [WIDTH-1:0] mem [0:WORDS-1];

    logic                        clrWe;
    logic [DEPTH-1:0]            clrAddr;
    logic [DEPTH-1:0]            wrIdx, rdIdx;
    logic                        wrInRange, rdInRange;
    logic                        wrEn, rdEn;
    logic [BE_W*BE_LANE_W-1:0]   laneMask;
    logic [WIDTH-1:0]            wMask;
    logic [WIDTH-1:0]            rdWord, rdData;
    logic [WIDTH-1:0]            dout_q;
    logic                        doutValid_q, oor_q;
    logic                        unusedBits;

    dualportram_clr_seq #(
        .DEPTH(DEPTH),
        .WORDS(WORDS)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .clear_req(clear_req),
        .busy     (busy),
        .clr_we   (clrWe),
        .clr_addr (clrAddr)
    );

    assign length    = 32'(WORDS);
    assign wrIdx     = waddress[DEPTH-1:0];
    assign rdIdx     = raddress[DEPTH-1:0];
    assign wrInRange = ({1'b0, wrIdx} < WORDS_L);
    assign rdInRange = ({1'b0, rdIdx} < WORDS_L);
    assign wrEn      = we && !busy;
    assign rdEn      = oe && !busy;

    // Expand byte enables to a per-bit mask, trimming the unimplemented bits of a partial top lane.
    always_comb begin
        laneMask = '0;
        for (int i = 0; i < BE_W; i++) begin
            laneMask[i*BE_LANE_W +: BE_LANE_W] = {BE_LANE_W{wbe[i]}};
        end
        laneMask[(BE_W-1)*BE_LANE_W +: BE_LANE_W] &= topLaneMask(WIDTH);
    end

    assign wMask = laneMask[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem[clrAddr] <= INIT_VALUE;
        end else if (wrEn && wrInRange) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (wMask[b]) begin
                    mem[wrIdx][b] <= din[b];
                end
            end
        end
    end

    assign rdWord = rdInRange ? mem[rdIdx] : '0;

`ifdef DUALPORTRAM_CLR_BYPASS_EN
    // Forwarding makes a colliding read return the word as it will be after this cycle's write.
    always_comb begin
        rdData = rdWord;
        if (wrEn && wrInRange && rdInRange && (wrIdx == rdIdx)) begin
            rdData = (rdWord & ~wMask) | (din & wMask);
        end
    end
`else
    assign rdData = rdWord;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            doutValid_q <= rdEn;
            if (rdEn) begin
                dout_q <= rdData;
            end
            if ((rdEn && !rdInRange) || (wrEn && !wrInRange)) begin
                oor_q <= 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign oor        = oor_q;

    assign unusedBits = ^{waddress[31:DEPTH], raddress[31:DEPTH], laneMask};

endmodule

// File: tb/tb_dualportram_clr.sv
// Scoreboard bench for dualportram_clr (WORDS=12, DEPTH=4, INIT_VALUE=DEADBEEF).
module tb_dualportram_clr;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 4;
    localparam int          WORDS = 12;
    localparam logic [31:0] INIT  = 32'hDEADBEEF;
`ifdef DUALPORTRAM_CLR_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'h0000_0055;
`else
    localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] length;
    logic        busy;
    logic        clear_req = 1'b0;
    logic [31:0] waddress = '0;
    logic [31:0] din = '0;
    logic [3:0]  wbe = '0;
    logic        we = 1'b0;
    logic [31:0] raddress = '0;
    logic        oe = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        oor;

    exp_t expQ[$];
    int   cycle = 0;
    int   total = 0;
    int   bad = 0;
    int   n;

    dualportram_clr #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .WORDS(WORDS),
        .INIT_VALUE(INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .length    (length),
        .busy      (busy),
        .clear_req (clear_req),
        .waddress  (waddress),
        .din       (din),
        .wbe       (wbe),
        .we        (we),
        .raddress  (raddress),
        .oe        (oe),
        .dout      (dout),
        .dout_valid(dout_valid),
        .oor       (oor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle of user traffic, issued at a falling edge; reads queue their expected result.
    task automatic applyStimulus(input bit doWe, input logic [31:0] wa, input logic [31:0] d,
                                 input logic [3:0] be, input bit doOe, input logic [31:0] ra,
                                 input logic [31:0] exp, input bit clr);
        exp_t e;
        we        = doWe;
        waddress  = wa;
        din       = d;
        wbe       = be;
        oe        = doOe;
        raddress  = ra;
        clear_req = clr;
        if (doOe) begin
            e.data = exp;
            e.cyc  = cycle + 1;
            expQ.push_back(e);
        end
        @(negedge clk);
        we        = 1'b0;
        oe        = 1'b0;
        clear_req = 1'b0;
    endtask

    // Counts falling edges with busy high; optionally pokes ignored traffic while busy.
    task automatic waitIdle(input bit poke, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            we        = poke && (cnt <= 3);
            oe        = poke && (cnt <= 3);
            waddress  = 32'd13;
            raddress  = 32'd13;
            din       = 32'h0BAD_0BAD;
            wbe       = 4'hF;
            clear_req = poke && (cnt == 5);
            @(negedge clk);
        end
        we        = 1'b0;
        oe        = 1'b0;
        clear_req = 1'b0;
    endtask

    // Monitor: every presented read result must match the oldest queued expectation and latency.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset === 1'b1 && dout_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rd_data", dout, e.data);
                checkOutput("rd_latency", 32'(cycle), 32'(e.cyc));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("rst_dout", dout, 32'd0);
        checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
        checkOutput("rst_oor", {31'd0, oor}, 32'd0);
        checkOutput("length", length, 32'd12);

        reset = 1'b1;
        waitIdle(1'b0, n);
        checkOutput("init_busy_cycles", 32'(n), 32'(WORDS));

        for (int a = 0; a < WORDS; a++) begin
            applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'(a), INIT, 1'b0);
        end

        applyStimulus(1'b1, 32'd5, 32'h11223344, 4'hF, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 32'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd5, 32'h11BB33DD, 1'b0);

        applyStimulus(1'b1, 32'd3, 32'h0, 4'hF, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 32'd3, 32'h55, 4'hF, 1'b1, 32'd3, COLL_EXP, 1'b0);
        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd3, 32'h55, 1'b0);

        applyStimulus(1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, 1'b1, 32'd5, 32'h11BB33DD, 1'b0);
        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd5, 32'h11BB33DD, 1'b0);
        checkOutput("oor_clean", {31'd0, oor}, 32'd0);

        applyStimulus(1'b1, 32'hFFFF_FFF7, 32'h77, 4'hF, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 32'd11, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0000_0017, 32'h77, 1'b0);
        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd11, 32'hCAFE_F00D, 1'b0);

        applyStimulus(1'b1, 32'd13, 32'h12345678, 4'hF, 1'b0, 0, 0, 1'b0);
        checkOutput("oor_write", {31'd0, oor}, 32'd1);
        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd13, 32'h0, 1'b0);
        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd1, INIT, 1'b0);
        checkOutput("oor_sticky", {31'd0, oor}, 32'd1);

        applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'd5, 32'h11BB33DD, 1'b1);
        checkOutput("clr_busy", {31'd0, busy}, 32'd1);
        we = 1'b1; oe = 1'b1; waddress = 32'd5; raddress = 32'd7; din = 32'h0; wbe = 4'hF;
        repeat (2) @(negedge clk);
        we = 1'b0; oe = 1'b0;
        checkOutput("busy_dout_hold", dout, 32'h11BB33DD);
        checkOutput("busy_valid", {31'd0, dout_valid}, 32'd0);
        checkOutput("busy_oor_hold", {31'd0, oor}, 32'd1);
        @(negedge clk);

        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd1);
        checkOutput("midrst_dout", dout, 32'd0);
        checkOutput("midrst_oor", {31'd0, oor}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        waitIdle(1'b1, n);
        checkOutput("resweep_busy_cycles", 32'(n), 32'(WORDS));
        checkOutput("busy_access_oor", {31'd0, oor}, 32'd0);
        checkOutput("busy_access_dout", dout, 32'd0);

        for (int a = 0; a < WORDS; a++) begin
            applyStimulus(1'b0, 0, 0, 4'h0, 1'b1, 32'(a), INIT, 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
